// File: rtl/seg_pkg.sv
// Shared constants, address field widths and scan FSM states for the
// segment display scan controller.
package seg_pkg;

    localparam int N_LANE = 8;
    localparam int N_COL  = 9;
    localparam int LANE_W = 3;
    localparam int COL_W  = 4;
    localparam int ADDR_W = COL_W + LANE_W;
    localparam int N_CELL = N_LANE * N_COL;

    typedef enum logic [1:0] {
        BLANK_PRE  = 2'd0,
        DRIVE      = 2'd1,
        BLANK_POST = 2'd2
    } scan_state_e;

    // One-hot column enable for a column index
    function automatic logic [N_COL-1:0] col_onehot(input logic [COL_W-1:0] col);
        logic [N_COL-1:0] one;
        one = {{(N_COL-1){1'b0}}, 1'b1};
        return one << col;
    endfunction

endpackage

// File: rtl/seg_frame_ram.sv
// Double-buffered 72x8 frame store. Writes always go to the back buffer,
// the column read port always looks at the front buffer, and a single
// bank-select flop decides which physical buffer is which.
module seg_frame_ram
    import seg_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   we,
    input  logic [COL_W-1:0]       wcol,
    input  logic [LANE_W-1:0]      wlane,
    input  logic [7:0]             wdata,
    input  logic                   swap,
    input  logic [COL_W-1:0]       rcol,
    output logic [N_LANE*8-1:0]    rdata
);

    logic [7:0]        mem0 [N_CELL];
    logic [7:0]        mem1 [N_CELL];
    logic              front_sel;
    logic              wr_ok;
    logic [ADDR_W-1:0] widx;

    // {col, lane} is exactly col*8 + lane, so the address doubles as the index
    assign widx  = {wcol, wlane};
    assign wr_ok = we && (wcol < COL_W'(N_COL));

    // Back-buffer write; uses the pre-swap bank so a write in the swap cycle
    // lands in the buffer that is about to become visible
    always_ff @(posedge clk) begin
        if (wr_ok && front_sel) begin
            mem0[widx] <= wdata;
        end
        if (wr_ok && !front_sel) begin
            mem1[widx] <= wdata;
        end
    end

    // Bank select: buffer 0 is front after reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            front_sel <= 1'b0;
        end else if (swap) begin
            front_sel <= ~front_sel;
        end
    end

    // Read all eight lanes of the requested column from the front buffer
    always_comb begin
        rdata = '0;
        for (int l = 0; l < N_LANE; l++) begin
            rdata[l*8 +: 8] = front_sel ? mem1[{rcol, LANE_W'(l)}]
                                        : mem0[{rcol, LANE_W'(l)}];
        end
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed scan controller for the 8-lane x 9-column segment display.
// Prescaler, slot timing, column FSM and frame-boundary swap logic.
//
// state      | meaning
// -----------+-------------------------------------------------------------
// BLANK_PRE  | dead time at slot start, all pins low
// DRIVE      | column enabled, lane bytes of the front buffer on the pins
// BLANK_POST | remainder of the slot after the on-time expired, pins low
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int CLK_DIV    = 1000,
    parameter int SLOT_TICKS = 16,
    parameter int DEAD_TICKS = 2
)(
    input  logic        CLK,
    input  logic        RST,
    input  logic        WE,
    input  logic [6:0]  WADDR,
    input  logic [7:0]  WDATA,
    input  logic [3:0]  BRIGHT,
    input  logic        SWAP_REQ,
    output logic        SWAP_PEND,
    output logic        FRAME,
    output logic [7:0]  SEG_A,
    output logic [7:0]  SEG_B,
    output logic [7:0]  SEG_C,
    output logic [7:0]  SEG_D,
    output logic [7:0]  SEG_E,
    output logic [7:0]  SEG_F,
    output logic [7:0]  SEG_G,
    output logic [7:0]  SEG_H,
    output logic [8:0]  SEG_SEL
);

    localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int TICK_W = $clog2(SLOT_TICKS);
    localparam int ON_MAX = SLOT_TICKS - DEAD_TICKS;

    logic [DIV_W-1:0]        div_q;
    logic [TICK_W-1:0]       tcnt_q;
    logic [TICK_W-1:0]       dcnt_q;
    logic [TICK_W-1:0]       on_q;
    logic [TICK_W-1:0]       on_clamp;
    logic [TICK_W-1:0]       on_eff;
    logic [COL_W-1:0]        col_q;
    scan_state_e             state_q;
    logic [N_COL-1:0]        sel_q;
    logic [N_LANE*8-1:0]     seg_q;
    logic [N_LANE*8-1:0]     col_data;
    logic                    frame_q;
    logic                    pend_q;
    logic                    tick;
    logic                    slot_start;
    logic                    slot_end;
    logic                    boundary;
    logic                    swap;

    assign tick       = (div_q == DIV_W'(CLK_DIV - 1));
    assign slot_start = (tcnt_q == '0) && (div_q == '0);
    assign slot_end   = tick && (tcnt_q == TICK_W'(SLOT_TICKS - 1));
    assign boundary   = slot_end && (col_q == COL_W'(N_COL - 1));
    assign swap       = boundary && pend_q;

    // On-time never exceeds the non-dead part of the slot
    assign on_clamp = (int'(BRIGHT) > ON_MAX) ? TICK_W'(ON_MAX) : TICK_W'(BRIGHT);
    // With CLK_DIV=1 the slot-start cycle can also be the DRIVE decision tick
    assign on_eff   = slot_start ? on_clamp : on_q;

    seg_frame_ram u_ram (
        .clk   (CLK),
        .rst   (RST),
        .we    (WE),
        .wcol  (WADDR[6:3]),
        .wlane (WADDR[2:0]),
        .wdata (WDATA),
        .swap  (swap),
        .rcol  (col_q),
        .rdata (col_data)
    );

    // Prescaler and tick-within-slot counter
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            div_q  <= '0;
            tcnt_q <= '0;
        end else if (tick) begin
            div_q  <= '0;
            tcnt_q <= slot_end ? '0 : tcnt_q + TICK_W'(1);
        end else begin
            div_q  <= div_q + DIV_W'(1);
        end
    end

    // Brightness latched once per slot so mid-slot changes wait a slot
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            on_q <= '0;
        end else if (slot_start) begin
            on_q <= on_clamp;
        end
    end

    // Column FSM with registered pin outputs; pins only ever go through zero
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= BLANK_PRE;
            col_q   <= '0;
            dcnt_q  <= '0;
            sel_q   <= '0;
            seg_q   <= '0;
            frame_q <= 1'b0;
        end else begin
            frame_q <= 1'b0;
            if (slot_end) begin
                col_q   <= (col_q == COL_W'(N_COL - 1)) ? '0 : col_q + COL_W'(1);
                frame_q <= (col_q == COL_W'(N_COL - 1));
            end
            if (tick) begin
                case (state_q)
                    BLANK_PRE: begin
                        if (tcnt_q == TICK_W'(DEAD_TICKS - 1)) begin
                            if (on_eff != '0) begin
                                state_q <= DRIVE;
                                dcnt_q  <= on_eff - TICK_W'(1);
                                sel_q   <= col_onehot(col_q);
                                seg_q   <= col_data;
                            end else begin
                                state_q <= BLANK_POST;
                            end
                        end
                    end
                    DRIVE: begin
                        if (slot_end) begin
                            state_q <= BLANK_PRE;
                            sel_q   <= '0;
                            seg_q   <= '0;
                        end else if (dcnt_q == '0) begin
                            state_q <= BLANK_POST;
                            sel_q   <= '0;
                            seg_q   <= '0;
                        end else begin
                            dcnt_q  <= dcnt_q - TICK_W'(1);
                        end
                    end
                    BLANK_POST: begin
                        if (slot_end) begin
                            state_q <= BLANK_PRE;
                        end
                    end
                    default: begin
                        state_q <= BLANK_PRE;
                        sel_q   <= '0;
                        seg_q   <= '0;
                    end
                endcase
            end
        end
    end

    // Swap request: a request landing on the boundary itself waits a frame
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            pend_q <= 1'b0;
        end else if (swap) begin
            pend_q <= SWAP_REQ;
        end else if (SWAP_REQ) begin
            pend_q <= 1'b1;
        end
    end

    assign SWAP_PEND = pend_q;
    assign FRAME     = frame_q;
    assign SEG_SEL   = sel_q;
    assign SEG_A     = seg_q[7:0];
    assign SEG_B     = seg_q[15:8];
    assign SEG_C     = seg_q[23:16];
    assign SEG_D     = seg_q[31:24];
    assign SEG_E     = seg_q[39:32];
    assign SEG_F     = seg_q[47:40];
    assign SEG_G     = seg_q[55:48];
    assign SEG_H     = seg_q[63:56];

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl with CLK_DIV=2, SLOT_TICKS=4, DEAD_TICKS=1:
// 8 cycles per slot (2 blank, up to 6 driven), 72 cycles per frame.
module tb_seg_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        we = 1'b0;
    logic [6:0]  waddr = '0;
    logic [7:0]  wdata = '0;
    logic [3:0]  bright = '0;
    logic        swap_req = 1'b0;
    logic        swap_pend;
    logic        frame;
    logic [7:0]  seg_a, seg_b, seg_c, seg_d, seg_e, seg_f, seg_g, seg_h;
    logic [8:0]  seg_sel;
    logic [63:0] segs;

    int total = 0;
    int bad   = 0;
    int cc    = 0;

    logic       ev_we   = 1'b0;
    logic [6:0] ev_addr = '0;
    logic [7:0] ev_data = '0;
    logic       ev_swap = 1'b0;

    typedef struct {
        logic [3:0] b;
        int         on_cyc;
    } br_vec_t;
    br_vec_t tbl [5];

    assign segs = {seg_h, seg_g, seg_f, seg_e, seg_d, seg_c, seg_b, seg_a};

    always #5 clk = ~clk;

    seg_scan_ctrl #(
        .CLK_DIV    (2),
        .SLOT_TICKS (4),
        .DEAD_TICKS (1)
    ) dut (
        .CLK       (clk),
        .RST       (rst),
        .WE        (we),
        .WADDR     (waddr),
        .WDATA     (wdata),
        .BRIGHT    (bright),
        .SWAP_REQ  (swap_req),
        .SWAP_PEND (swap_pend),
        .FRAME     (frame),
        .SEG_A     (seg_a),
        .SEG_B     (seg_b),
        .SEG_C     (seg_c),
        .SEG_D     (seg_d),
        .SEG_E     (seg_e),
        .SEG_F     (seg_f),
        .SEG_G     (seg_g),
        .SEG_H     (seg_h),
        .SEG_SEL   (seg_sel)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] col_data(input int c, input logic [7:0] xv, input bit ff0);
        logic [63:0] d;
        for (int l = 0; l < 8; l++) begin
            d[l*8 +: 8] = 8'(c * 8 + l) ^ xv;
        end
        if (ff0 && c == 0) begin
            d[7:0] = 8'hFF;
        end
        return d;
    endfunction

    // Observe one full slot starting at its cycle 0 negedge; optionally fire
    // the staged write/swap event at cycle act_k and change BRIGHT at cycle 4.
    task automatic check_slot(input int c, input int exp_on, input logic [63:0] exp_d,
                              input logic exp_frm, input logic exp_pend,
                              input logic [3:0] nb, input int act_k);
        int         on_n = 0;
        int         first = -1;
        int         errs = 0;
        logic [8:0] exp_sel;
        logic       exp_f;
        exp_sel = 9'd1 << c;
        for (int k = 0; k < 8; k++) begin
            if (seg_sel != 9'd0) begin
                on_n++;
                if (first < 0) first = k;
                if (seg_sel !== exp_sel || segs !== exp_d) errs++;
            end else if (segs !== 64'd0) begin
                errs++;
            end
            exp_f = (k == 0) ? exp_frm : 1'b0;
            if (frame !== exp_f) errs++;
            if (k == 7) chk($sformatf("pend_col%0d", c), 64'(swap_pend), 64'(exp_pend));
            we       = 1'b0;
            swap_req = 1'b0;
            if (k == act_k) begin
                we       = ev_we;
                waddr    = ev_addr;
                wdata    = ev_data;
                swap_req = ev_swap;
            end
            if (k == 4) bright = nb;
            @(negedge clk);
        end
        chk($sformatf("on_cycles_col%0d", c), 64'(on_n), 64'(exp_on));
        if (exp_on > 0) chk($sformatf("lead_blank_col%0d", c), 64'(first), 64'd2);
        chk($sformatf("sel_data_frame_col%0d", c), 64'(errs), 64'd0);
    endtask

    task automatic slot(input logic [7:0] xv, input bit ff0, input logic pend, input int act_k);
        check_slot(cc, 6, col_data(cc, xv, ff0), (cc == 0), pend, 4'd3, act_k);
        cc = (cc + 1) % 9;
    endtask

    task automatic write_frame(input logic [7:0] xv);
        for (int i = 0; i < 72; i++) begin
            we    = 1'b1;
            waddr = 7'(i);
            wdata = 8'(i) ^ xv;
            @(negedge clk);
        end
        we = 1'b0;
    endtask

    initial begin
        int idle_err;
        int f1;
        int f2;
        int found;

        tbl[0] = '{b: 4'd15, on_cyc: 6};
        tbl[1] = '{b: 4'd1,  on_cyc: 2};
        tbl[2] = '{b: 4'd0,  on_cyc: 0};
        tbl[3] = '{b: 4'd2,  on_cyc: 4};
        tbl[4] = '{b: 4'd3,  on_cyc: 6};

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_sel", 64'(seg_sel), 64'd0);
        chk("rst_segs", segs, 64'd0);
        chk("rst_frame", 64'(frame), 64'd0);
        chk("rst_pend", 64'(swap_pend), 64'd0);

        // Idle with BRIGHT=0 for two frames
        rst = 1'b0;
        idle_err = 0;
        f1 = -1;
        f2 = -1;
        for (int n = 1; n <= 150; n++) begin
            @(negedge clk);
            if (seg_sel != 9'd0 || segs != 64'd0 || swap_pend) idle_err++;
            if (frame) begin
                if (f1 < 0) f1 = n;
                else if (f2 < 0) f2 = n;
                else idle_err++;
            end
        end
        chk("idle_dark", 64'(idle_err), 64'd0);
        chk("idle_frame1", 64'(f1), 64'd72);
        chk("idle_frame2", 64'(f2), 64'd144);

        // Fill back buffer, then out-of-range columns that must be dropped
        write_frame(8'h00);
        we = 1'b1; waddr = 7'h48; wdata = 8'hEE;
        @(negedge clk);
        waddr = 7'h4F; wdata = 8'hEE;
        @(negedge clk);
        we = 1'b0;
        swap_req = 1'b1;
        bright = 4'd3;
        @(negedge clk);
        swap_req = 1'b0;
        chk("pend_set", 64'(swap_pend), 64'd1);

        found = 0;
        for (int n = 0; n < 200 && found == 0; n++) begin
            @(negedge clk);
            if (frame) found = 1;
        end
        chk("sync_frame", 64'(found), 64'd1);
        chk("pend_clear_at_swap", 64'(swap_pend), 64'd0);

        // Scan order over one frame and wrap to column 0
        cc = 0;
        for (int c = 0; c < 9; c++) slot(8'h00, 1'b0, 1'b0, -1);
        slot(8'h00, 1'b0, 1'b0, -1);

        // Brightness table: new value set mid-slot applies from the next slot
        begin
            int cur_on;
            cur_on = 6;
            for (int i = 0; i < 5; i++) begin
                check_slot(cc, cur_on, col_data(cc, 8'h00, 1'b0), (cc == 0), 1'b0, tbl[i].b, -1);
                cur_on = tbl[i].on_cyc;
                cc = (cc + 1) % 9;
            end
            check_slot(cc, cur_on, col_data(cc, 8'h00, 1'b0), (cc == 0), 1'b0, 4'd3, -1);
            cc = (cc + 1) % 9;
        end

        // Swap round 1: mid-frame request, repeated while pending
        write_frame(8'h80);
        for (int i = 0; i < 6; i++) slot(8'h00, 1'b0, 1'b0, -1);
        ev_we = 1'b0; ev_swap = 1'b1;
        slot(8'h00, 1'b0, 1'b1, 0);
        slot(8'h00, 1'b0, 1'b1, 3);
        ev_swap = 1'b0;
        for (int i = 0; i < 3; i++) slot(8'h00, 1'b0, 1'b1, -1);
        chk("pend_drop_r1", 64'(swap_pend), 64'd0);
        slot(8'h80, 1'b0, 1'b0, -1);
        slot(8'h80, 1'b0, 1'b0, -1);

        // Swap round 2: write in the swap cycle lands in the new front
        ev_swap = 1'b1;
        slot(8'h80, 1'b0, 1'b1, 0);
        ev_swap = 1'b0;
        for (int i = 0; i < 5; i++) slot(8'h80, 1'b0, 1'b1, -1);
        ev_we = 1'b1; ev_addr = 7'h00; ev_data = 8'hFF;
        slot(8'h80, 1'b0, 1'b1, 7);
        ev_we = 1'b0;
        chk("pend_drop_r2", 64'(swap_pend), 64'd0);
        chk("seg_a_col0_ff", 64'(col_data(0, 8'h00, 1'b1) & 64'hFF), 64'hFF);
        for (int i = 0; i < 8; i++) slot(8'h00, 1'b1, 1'b0, -1);

        // Swap round 3: request in the boundary cycle waits one frame
        ev_swap = 1'b1;
        slot(8'h00, 1'b1, 1'b0, 7);
        ev_swap = 1'b0;
        chk("pend_deferred", 64'(swap_pend), 64'd1);
        for (int i = 0; i < 9; i++) slot(8'h00, 1'b1, 1'b1, -1);
        chk("pend_drop_r3", 64'(swap_pend), 64'd0);
        slot(8'h80, 1'b0, 1'b0, -1);

        // Async reset while column 1 is driven, with a swap pending
        swap_req = 1'b1;
        @(negedge clk);
        swap_req = 1'b0;
        repeat (3) @(negedge clk);
        chk("pre_rst_sel", 64'(seg_sel), 64'h002);
        chk("pre_rst_pend", 64'(swap_pend), 64'd1);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_sel", 64'(seg_sel), 64'd0);
        chk("async_rst_segs", segs, 64'd0);
        chk("async_rst_pend", 64'(swap_pend), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        check_slot(0, 6, col_data(0, 8'h80, 1'b0), 1'b0, 1'b0, 4'd3, -1);
        check_slot(1, 6, col_data(1, 8'h80, 1'b0), 1'b0, 1'b0, 4'd3, -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
